// File: rtl/count_sequencer.sv
// count_sequencer: bounded run controller for the prescaled 4-bit counter.
// It owns the rate divider and the count register. It counts up from 0 to
// Limit, or down from Limit to 0, one step per divided period.
// Optional feature macro: COUNT_SEQUENCER_AUTO_RELOAD_EN. When it is defined,
// the count reloads at the end value, the run never stops, and Done pulses.
module count_sequencer #(
  parameter int BoardFreq = 50_000_000,
  parameter int Bits      = 27
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Abort,
  input  logic       Dir,
  input  logic [1:0] Rate,
  input  logic [3:0] Limit,
  output logic [3:0] Q,
  output logic       Tick,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  // Terminal prescaler values for the four rate selects (div - 1).
  localparam logic [Bits-1:0] DIV_M1_0 = Bits'((BoardFreq >> 0) - 1);
  localparam logic [Bits-1:0] DIV_M1_1 = Bits'((BoardFreq >> 1) - 1);
  localparam logic [Bits-1:0] DIV_M1_2 = Bits'((BoardFreq >> 2) - 1);
  localparam logic [Bits-1:0] DIV_M1_3 = Bits'((BoardFreq >> 3) - 1);

  state_t          state, state_n;
  logic [Bits-1:0] presc, presc_n;
  logic [Bits-1:0] div_m1;
  logic [3:0]      q_n;
  logic            tick_n, busy_n, done_n;

  // Run configuration captured on an accepted Start.
  logic            dir_r, dir_n;
  logic [1:0]      rate_r, rate_n;
  logic [3:0]      limit_r, limit_n;

  logic [3:0]      end_val;
  logic            term;
  logic            reload;
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
  logic [3:0]      start_val;
`endif

  // Decode the latched rate into the terminal prescaler count.
  always_comb begin
    div_m1 = DIV_M1_0;
    case (rate_r)
      2'd0: div_m1 = DIV_M1_0;
      2'd1: div_m1 = DIV_M1_1;
      2'd2: div_m1 = DIV_M1_2;
      2'd3: div_m1 = DIV_M1_3;
      default: div_m1 = DIV_M1_0;
    endcase
  end

  // The end value depends on the run direction. The prescaler is terminal
  // on the last cycle of each divided period.
  always_comb begin
    end_val = dir_r ? 4'd0 : limit_r;
    term    = (presc == div_m1);
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
    start_val = dir_r ? limit_r : 4'd0;
`endif
  end

  // Next state and next register values. Abort has priority over Pause.
  // Pause has priority over a tick. Start is only looked at outside a run.
  always_comb begin
    state_n = state;
    presc_n = presc;
    q_n     = Q;
    tick_n  = 1'b0;
    reload  = 1'b0;
    dir_n   = dir_r;
    rate_n  = rate_r;
    limit_n = limit_r;

    case (state)
      IDLE, DONE: begin
        if (state == IDLE) q_n = 4'd0;
        if (Abort) begin
          state_n = IDLE;
          q_n     = 4'd0;
        end else if (Start) begin
          dir_n   = Dir;
          rate_n  = Rate;
          limit_n = Limit;
          q_n     = Dir ? Limit : 4'd0;
          presc_n = '0;
          state_n = RUN;
        end
      end

      RUN, PAUSE: begin
        if (Abort) begin
          state_n = IDLE;
          q_n     = 4'd0;
          presc_n = '0;
        end else if (Pause) begin
          // Freeze in place. The prescaler and Q keep their values.
          state_n = PAUSE;
        end else begin
          // Leaving PAUSE resumes on this same edge, so the hold lasts
          // exactly as many cycles as Pause was high.
          state_n = RUN;
          if (term) begin
            presc_n = '0;
            tick_n  = 1'b1;
            if (Q != end_val) begin
              q_n = dir_r ? (Q - 4'd1) : (Q + 4'd1);
            end else begin
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
              q_n    = start_val;
              reload = 1'b1;
`else
              state_n = DONE;
`endif
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        q_n     = 4'd0;
        presc_n = '0;
      end
    endcase

    busy_n = (state_n == RUN) || (state_n == PAUSE);
    done_n = (state_n == DONE) || reload;
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      presc   <= '0;
      Q       <= 4'd0;
      Tick    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      dir_r   <= 1'b0;
      rate_r  <= 2'd0;
      limit_r <= 4'd0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      Q       <= q_n;
      Tick    <= tick_n;
      Busy    <= busy_n;
      Done    <= done_n;
      dir_r   <= dir_n;
      rate_r  <= rate_n;
      limit_r <= limit_n;
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with BoardFreq=8, so Rate 0..3 gives div 8/4/2/1.
// Edge 0 is the edge that accepts Start. Outputs are sampled 1 time unit after each edge.
module tb_count_sequencer;

  logic       Clk = 1'b0;
  logic       Rst, Start, Pause, Abort, Dir;
  logic [1:0] Rate;
  logic [3:0] Limit;
  logic [3:0] Q;
  logic       Tick, Busy, Done;

  int checks = 0;
  int errors = 0;

  count_sequencer #(.BoardFreq(8), .Bits(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pause(Pause), .Abort(Abort),
    .Dir(Dir), .Rate(Rate), .Limit(Limit),
    .Q(Q), .Tick(Tick), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Pulse Start for one edge (edge 0). On return, that edge has been sampled.
  task automatic do_start(input logic d, input logic [1:0] r, input logic [3:0] l);
    Dir = d; Rate = r; Limit = l; Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 0; Pause = 0; Abort = 0; Dir = 0; Rate = 0; Limit = 0;
    step(); step();
    Rst = 1'b0;
    checks++;
    if ({Q, Tick, Busy, Done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_init got Q=%0d T=%b B=%b D=%b want all 0", Q, Tick, Busy, Done);
    end
    // Mid-run reset: up, div 1, Limit 7. After three edges Q is 3.
    do_start(1'b0, 2'd3, 4'd7);
    step(); step(); step();
    checks++;
    if (Q !== 4'd3 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun got Q=%0d B=%b want Q=3 B=1", Q, Busy);
    end
    Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({Q, Tick, Busy, Done} !== 7'b0) begin
        errors++;
        $display("FAIL reset_midrun[%0d] got Q=%0d T=%b B=%b D=%b want all 0", i, Q, Tick, Busy, Done);
      end
    end
    Rst = 1'b0;
    step();
    checks++;
    if ({Q, Busy, Done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle got Q=%0d B=%b D=%b want all 0", Q, Busy, Done);
    end
  endtask

`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [3:0] eq [1:7];
    logic       ed [1:7];
    eq = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
    ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_start(1'b0, 2'd3, 4'd2);
    checks++;
    if (Q !== 4'd0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_start got Q=%0d B=%b want Q=0 B=1", Q, Busy);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (Q !== eq[k] || Done !== ed[k] || Busy !== 1'b1 || Tick !== 1'b1) begin
        errors++;
        $display("FAIL reload_e%0d got Q=%0d D=%b B=%b T=%b want Q=%0d D=%b B=1 T=1",
                 k, Q, Done, Busy, Tick, eq[k], ed[k]);
      end
    end
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    checks++;
    if ({Q, Tick, Busy, Done} !== 7'b0) begin
      errors++;
      $display("FAIL reload_abort got Q=%0d T=%b B=%b D=%b want all 0", Q, Tick, Busy, Done);
    end
  endtask
`else
  task automatic test_up();
    logic [3:0] eq [1:8];
    int ticks;
    eq = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3};
    ticks = 0;
    do_start(1'b0, 2'd2, 4'd3);
    checks++;
    if (Q !== 4'd0 || Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL up_start got Q=%0d B=%b D=%b want Q=0 B=1 D=0", Q, Busy, Done);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (Tick === 1'b1) ticks++;
      checks++;
      if (Q !== eq[k] || Done !== (k == 8) || Tick !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL up_e%0d got Q=%0d D=%b T=%b want Q=%0d D=%b T=%b",
                 k, Q, Done, Tick, eq[k], (k == 8), (k % 2 == 0));
      end
    end
    checks++;
    if (ticks != 4 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL up_ticks got ticks=%0d B=%b want ticks=4 B=0", ticks, Busy);
    end
    step();
    checks++;
    if (Q !== 4'd3 || Done !== 1'b1 || Tick !== 1'b0) begin
      errors++;
      $display("FAIL up_hold got Q=%0d D=%b T=%b want Q=3 D=1 T=0", Q, Done, Tick);
    end
  endtask

  task automatic test_down();
    do_start(1'b1, 2'd3, 4'd5);
    checks++;
    if (Q !== 4'd5 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL down_start got Q=%0d B=%b want Q=5 B=1", Q, Busy);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (Q !== ((k < 5) ? 4'(5 - k) : 4'd0) || Done !== (k == 6) || Tick !== 1'b1) begin
        errors++;
        $display("FAIL down_e%0d got Q=%0d D=%b T=%b want Q=%0d D=%b T=1",
                 k, Q, Done, Tick, ((k < 5) ? 5 - k : 0), (k == 6));
      end
    end
  endtask

  task automatic test_pause();
    do_start(1'b0, 2'd2, 4'd3);
    step(); step(); step();
    checks++;
    if (Q !== 4'd1) begin
      errors++;
      $display("FAIL pause_pre got Q=%0d want 1", Q);
    end
    Pause = 1'b1;
    for (int k = 4; k <= 13; k++) begin
      step();
      checks++;
      if (Q !== 4'd1 || Tick !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL pause_e%0d got Q=%0d T=%b B=%b D=%b want Q=1 T=0 B=1 D=0",
                 k, Q, Tick, Busy, Done);
      end
    end
    Pause = 1'b0;
    step(); // edge 14
    checks++;
    if (Q !== 4'd2 || Tick !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume got Q=%0d T=%b want Q=2 T=1", Q, Tick);
    end
    step(); step(); step(); // edge 17
    checks++;
    if (Q !== 4'd3 || Done !== 1'b0) begin
      errors++;
      $display("FAIL pause_e17 got Q=%0d D=%b want Q=3 D=0", Q, Done);
    end
    step(); // edge 18
    checks++;
    if (Done !== 1'b1 || Q !== 4'd3) begin
      errors++;
      $display("FAIL pause_done got Q=%0d D=%b want Q=3 D=1", Q, Done);
    end
  endtask

  task automatic test_abort_pause();
    do_start(1'b0, 2'd2, 4'd3);
    step(); step();
    Abort = 1'b1; Pause = 1'b1;
    step();
    Abort = 1'b0; Pause = 1'b0;
    checks++;
    if ({Q, Tick, Busy, Done} !== 7'b0) begin
      errors++;
      $display("FAIL abort_pause got Q=%0d T=%b B=%b D=%b want all 0", Q, Tick, Busy, Done);
    end
    // Start while busy must not disturb the run or its captured config.
    do_start(1'b0, 2'd2, 4'd3);
    step(); // edge 1
    Dir = 1'b1; Rate = 2'd3; Limit = 4'd9; Start = 1'b1;
    step(); // edge 2
    Start = 1'b0;
    checks++;
    if (Q !== 4'd1 || Tick !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start got Q=%0d T=%b B=%b want Q=1 T=1 B=1", Q, Tick, Busy);
    end
    step(); step(); // edge 4
    checks++;
    if (Q !== 4'd2) begin
      errors++;
      $display("FAIL busy_e4 got Q=%0d want 2", Q);
    end
    step(); step(); step(); step(); // edge 8
    checks++;
    if (Q !== 4'd3 || Done !== 1'b1) begin
      errors++;
      $display("FAIL busy_done got Q=%0d D=%b want Q=3 D=1", Q, Done);
    end
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    checks++;
    if ({Q, Busy, Done} !== 6'b0) begin
      errors++;
      $display("FAIL done_abort got Q=%0d B=%b D=%b want all 0", Q, Busy, Done);
    end
  endtask

  // Limit 0: the first tick goes straight to DONE.
  task automatic test_limit_zero();
    do_start(1'b0, 2'd1, 4'd0);
    step(); step(); step();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL lim0_e3 got D=%b B=%b want D=0 B=1", Done, Busy);
    end
    step();
    checks++;
    if (Done !== 1'b1 || Q !== 4'd0 || Tick !== 1'b1) begin
      errors++;
      $display("FAIL lim0_done got Q=%0d D=%b T=%b want Q=0 D=1 T=1", Q, Done, Tick);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_up();
    test_down();
    test_pause();
    test_abort_pause();
    test_limit_zero();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run controller for the prescaled 4-bit board counter: owns the frequency divider and the 4-bit count register, and sequences them through start / pause / abort / completion. Replaces free-running 1 Hz counting with a bounded run: count up from 0 to `Limit`, or down from `Limit` to 0, at a selectable rate. Sits between board push-buttons/switches (already debounced) and the display logic that reads `Q`.

## Interface
- `BoardFreq`, 50_000_000: board clock frequency in Hz; base divide ratio. Must be ≥ 8.
- `Bits`, 27: prescaler width; must hold `BoardFreq-1`.
- `Clk` in 1: board clock; all logic on rising edge.
- `Rst` in 1: reset, synchronous, active-high.
- `Start` in 1: begin a run. Honoured in IDLE and DONE only.
- `Pause` in 1: level; freezes a run while high.
- `Abort` in 1: cancel the run and return to IDLE.
- `Dir` in 1: 0 = up, 1 = down. Sampled on accepted `Start`.
- `Rate` in 2: divide select; div = `BoardFreq >> Rate`. Sampled on accepted `Start`.
- `Limit` in 4: run bound. Sampled on accepted `Start`.
- `Q` out 4: count value.
- `Tick` out 1: one-cycle pulse coincident with every `Q` update or reload.
- `Busy` out 1: high in RUN and PAUSE.
- `Done` out 1: high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (`Rst`=1 at an edge): state IDLE, `Q`=0, prescaler=0, `Tick`=0, `Busy`=0, `Done`=0. Latched `Dir`/`Rate`/`Limit` cleared to 0.
- Priority within a cycle: `Rst` > `Abort` > `Pause` > tick > `Start`.
- IDLE: `Q`=0. On `Start`: latch `Dir`, `Rate`, `Limit`; `Q` ← start value (0 if up, `Limit` if down); prescaler ← 0; go to RUN.
- RUN:
  - `Abort` → IDLE, `Q` ← 0.
  - Else `Pause` → PAUSE. Prescaler and `Q` hold.
  - Else prescaler increments. When prescaler = div−1: prescaler ← 0 and `Tick` ← 1.
    - If `Q` ≠ end value (`Limit` if up, 0 if down): `Q` steps ±1.
    - If `Q` = end value: go to DONE with `Q` held (see Configuration).
  - `Start` is ignored.
- PAUSE: `Abort` → IDLE, `Q` ← 0. `Pause` low → RUN, resuming from the frozen prescaler value. No ticks while paused. `Start` is ignored.
- DONE: `Q` holds the end value. `Start` begins a new run (same as from IDLE). `Abort` → IDLE.
- `Limit`=0: start value equals end value, so the first tick enters DONE.
- Arithmetic is 4-bit. The end-value check prevents wrap in normal operation.

## Timing
- All outputs are registered.
- `Start` accepted at edge 0: prescaler=0 and `Busy`=1 after edge 0.
- First `Q` step occurs at edge div. Later steps follow every div RUN cycles.
- Completion: `Done` rises at edge (|end−start|+1)·div after `Start`, plus the number of paused cycles.
- `Tick` is high for exactly the one cycle following each terminal prescaler edge.
- `Abort` or `Rst` mid-run takes effect at that edge. No tick is emitted on that edge.
- Changing `Dir`/`Rate`/`Limit` during a run has no effect until the next accepted `Start`.

## Configuration
- `COUNT_SEQUENCER_AUTO_RELOAD_EN` defined:
  - At end value plus tick, `Q` ← start value and the state stays RUN. The run is continuous.
  - `Done` becomes a one-cycle pulse on each reload. DONE is unreachable.
  - `Busy` stays 1 until `Abort` or `Rst`.
- Not defined: single-shot behaviour as described under Operation.

## Test plan
Benches use `BoardFreq`=8, so `Rate` 0..3 gives div 8/4/2/1.
- Reset: hold `Rst` for 2 cycles mid-run → `Q`=0, `Busy`=0, `Done`=0, `Tick`=0. Next `Start` runs normally.
- Up run, `Limit`=3, `Rate`=2, `Dir`=0:
  - `Q` = 0→1→2→3 at edges 2, 4, 6 after `Start`.
  - `Done`=1 at edge 8.
  - Four `Tick` pulses in total.
- Down run, `Limit`=5, `Rate`=3, `Dir`=1: `Q` = 5,4,3,2,1,0 on consecutive cycles; `Done` at edge 6.
- Pause: assert `Pause` for 10 cycles mid-run (`Limit`=3, `Rate`=2) → `Q` and `Tick` frozen throughout; `Done` arrives exactly at edge 18.
- Simultaneous `Abort`+`Pause` in RUN → IDLE, `Q`=0. `Start` while `Busy` → ignored, latched config unchanged.
- `COUNT_SEQUENCER_AUTO_RELOAD_EN` with `Limit`=2, `Rate`=3, up:
  - `Q` = 0,1,2,0,1,2…
  - `Done` pulses each reload; `Busy` stays 1.
  - `Abort` → IDLE.
